// File: rtl/bist_scan_controller.sv
// BIST sequencer for the scan-inserted cut: an LFSR drives scan and primary-input
// stimulus, shift/capture is sequenced through scan_en, and a MISR compacts responses.
module bist_scan_controller #(
  parameter int unsigned CHAIN_LEN     = 16,
  parameter int unsigned PATTERN_COUNT = 30,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter logic [15:0] GOLDEN_SIG    = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        bist_start,
  output logic        scan_en,
  output logic        scan_in,
  input  logic        scan_out,
  output logic [4:0]  pi_out,
  input  logic [8:0]  po_in,
  output logic        bist_busy,
  output logic        bist_done,
  output logic        bist_pass,
  output logic [15:0] signature
);

  localparam int unsigned SC_W = $clog2(CHAIN_LEN + 1);
  localparam int unsigned PC_W = $clog2(PATTERN_COUNT + 1);
  localparam logic [SC_W-1:0] SHIFT_LAST = SC_W'(CHAIN_LEN - 1);
  localparam logic [PC_W-1:0] PAT_LAST   = PC_W'(PATTERN_COUNT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_CAPTURE,
    S_UNLOAD,
    S_COMPARE,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [15:0]     misr_q, misr_d;
  logic [SC_W-1:0] shift_cnt_q, shift_cnt_d;
  logic [PC_W-1:0] pat_cnt_q, pat_cnt_d;
  logic            pass_q, pass_d;

  // Both registers use x^16+x^14+x^13+x^11+1; the MISR additionally XORs in d.
  function automatic logic [15:0] poly_step(input logic [15:0] r, input logic [15:0] d);
    return {r[14:0], r[15] ^ r[13] ^ r[12] ^ r[10]} ^ d;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      lfsr_q      <= LFSR_SEED;
      misr_q      <= '0;
      shift_cnt_q <= '0;
      pat_cnt_q   <= '0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      misr_q      <= misr_d;
      shift_cnt_q <= shift_cnt_d;
      pat_cnt_q   <= pat_cnt_d;
      pass_q      <= pass_d;
    end
  end

  // NOTE: every signal driven here gets a hold default first, so no path
  // through the case statement can infer a latch.
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    misr_d      = misr_q;
    shift_cnt_d = shift_cnt_q;
    pat_cnt_d   = pat_cnt_q;
    pass_d      = pass_q;

    unique case (state_q)
      S_IDLE: begin
        if (bist_start) begin
          state_d     = S_SHIFT;
          lfsr_d      = LFSR_SEED;
          misr_d      = '0;
          shift_cnt_d = '0;
          pat_cnt_d   = '0;
          pass_d      = 1'b0;
        end
      end
      S_SHIFT: begin
        lfsr_d = poly_step(lfsr_q, 16'h0000);
        misr_d = poly_step(misr_q, {15'b0, scan_out});
        if (shift_cnt_q == SHIFT_LAST) begin
          shift_cnt_d = '0;
          state_d     = S_CAPTURE;
        end else begin
          shift_cnt_d = shift_cnt_q + SC_W'(1);
        end
      end
      S_CAPTURE: begin
        misr_d    = poly_step(misr_q, {7'b0, po_in});
        pat_cnt_d = pat_cnt_q + PC_W'(1);
        state_d   = (pat_cnt_d == PAT_LAST) ? S_UNLOAD : S_SHIFT;
      end
      S_UNLOAD: begin
        misr_d = poly_step(misr_q, {15'b0, scan_out});
        if (shift_cnt_q == SHIFT_LAST) begin
          shift_cnt_d = '0;
          state_d     = S_COMPARE;
        end else begin
          shift_cnt_d = shift_cnt_q + SC_W'(1);
        end
      end
      S_COMPARE: begin
        pass_d  = (misr_q == GOLDEN_SIG);
        state_d = S_DONE;
      end
      S_DONE: begin
        if (!bist_start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode from registered state only, so reset clears them asynchronously.
  always_comb begin
    scan_en   = (state_q == S_SHIFT) || (state_q == S_UNLOAD);
    scan_in   = (state_q == S_SHIFT) && lfsr_q[15];
    pi_out    = (state_q == S_CAPTURE) ? lfsr_q[4:0] : 5'b0;
    bist_busy = (state_q == S_SHIFT) || (state_q == S_CAPTURE) ||
                (state_q == S_UNLOAD) || (state_q == S_COMPARE);
    bist_done = (state_q == S_DONE);
    bist_pass = pass_q;
    signature = misr_q;
  end

endmodule

// File: tb/tb_bist_scan_controller.sv
// Self-checking bench: a default-size controller drives a small behavioural cut model,
// a 1x1 controller sees random responses; both are checked against a schedule-level model.
module tb_bist_scan_controller;

  localparam logic [15:0] B_SEED = 16'h8001;

  logic clock, reset, start_a, start_b;
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], ^(l & 16'hB400)};
  endfunction

  function automatic logic [15:0] misr_next(input logic [15:0] m, input logic [15:0] d);
    logic [15:0] r;
    r    = m << 1;
    r[0] = ^(m & 16'hB400);
    return r ^ d;
  endfunction

  // Behavioural cut: 16-flop chain, capture mixes chain and PIs; all-zero is a fixed point.
  function automatic logic [15:0] cut_capture(input logic [15:0] c, input logic [4:0] pi);
    return {c[14:0], c[15]} ^ (c & {c[0], c[15:1]}) ^ {pi[0], pi, pi, pi};
  endfunction

  function automatic logic [8:0] cut_po(input logic [15:0] c, input logic [4:0] pi);
    return {c[15] ^ pi[4], c[3] & pi[0], c[8:2] ^ {2'b00, pi}};
  endfunction

  function automatic logic [15:0] ref_golden();
    logic [15:0] lfsr, misr, chain;
    logic [4:0]  pi;
    lfsr  = 16'hACE1;
    misr  = '0;
    chain = '0;
    for (int p = 0; p < 30; p++) begin
      for (int c = 0; c < 16; c++) begin
        misr  = misr_next(misr, {15'b0, chain[15]});
        chain = {chain[14:0], lfsr[15]};
        lfsr  = lfsr_next(lfsr);
      end
      pi    = lfsr[4:0];
      misr  = misr_next(misr, {7'b0, cut_po(chain, pi)});
      chain = cut_capture(chain, pi);
    end
    for (int c = 0; c < 16; c++) begin
      misr  = misr_next(misr, {15'b0, chain[15]});
      chain = {chain[14:0], 1'b0};
    end
    return misr;
  endfunction

  localparam logic [15:0] GOLD_A = ref_golden();

  logic        a_scan_en, a_scan_in, a_scan_out, a_busy, a_done, a_pass;
  logic [4:0]  a_pi_out;
  logic [8:0]  a_po_in;
  logic [15:0] a_sig;
  logic        f_scan_en, f_scan_in, f_busy, f_done, f_pass;
  logic [4:0]  f_pi_out;
  logic [15:0] f_sig;
  logic        b_scan_en, b_scan_in, b_scan_out, b_busy, b_done, b_pass;
  logic [4:0]  b_pi_out;
  logic [8:0]  b_po_in;
  logic [15:0] b_sig;
  logic [15:0] chain;

  bist_scan_controller #(.CHAIN_LEN(16), .PATTERN_COUNT(30), .LFSR_SEED(16'hACE1),
                         .GOLDEN_SIG(GOLD_A)) dut_a (
    .clock(clock), .reset(reset), .bist_start(start_a), .scan_en(a_scan_en),
    .scan_in(a_scan_in), .scan_out(a_scan_out), .pi_out(a_pi_out), .po_in(a_po_in),
    .bist_busy(a_busy), .bist_done(a_done), .bist_pass(a_pass), .signature(a_sig));

  bist_scan_controller #(.CHAIN_LEN(16), .PATTERN_COUNT(30), .LFSR_SEED(16'hACE1),
                         .GOLDEN_SIG(GOLD_A ^ 16'h0001)) dut_f (
    .clock(clock), .reset(reset), .bist_start(start_a), .scan_en(f_scan_en),
    .scan_in(f_scan_in), .scan_out(a_scan_out), .pi_out(f_pi_out), .po_in(a_po_in),
    .bist_busy(f_busy), .bist_done(f_done), .bist_pass(f_pass), .signature(f_sig));

  bist_scan_controller #(.CHAIN_LEN(1), .PATTERN_COUNT(1), .LFSR_SEED(B_SEED),
                         .GOLDEN_SIG(16'h0000)) dut_b (
    .clock(clock), .reset(reset), .bist_start(start_b), .scan_en(b_scan_en),
    .scan_in(b_scan_in), .scan_out(b_scan_out), .pi_out(b_pi_out), .po_in(b_po_in),
    .bist_busy(b_busy), .bist_done(b_done), .bist_pass(b_pass), .signature(b_sig));

  always @(posedge clock or negedge reset) begin
    if (!reset)         chain <= '0;
    else if (a_scan_en) chain <= {chain[14:0], a_scan_in};
    else                chain <= cut_capture(chain, a_pi_out);
  end
  assign a_scan_out = chain[15];
  assign a_po_in    = cut_po(chain, a_pi_out);

  logic [8:0]  a_vec, f_vec, b_vec;
  logic [25:0] a_all, f_all, b_all;
  assign a_vec = {a_scan_en, a_scan_in, a_pi_out, a_busy, a_done};
  assign f_vec = {f_scan_en, f_scan_in, f_pi_out, f_busy, f_done};
  assign b_vec = {b_scan_en, b_scan_in, b_pi_out, b_busy, b_done};
  assign a_all = {a_vec, a_pass, a_sig};
  assign f_all = {f_vec, f_pass, f_sig};
  assign b_all = {b_vec, b_pass, b_sig};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Called at a falling edge; the start edge is the next rising edge.
  task automatic run_bist(input int sel, input int abort_at, input bit stuck);
    int          c_len, p_cnt, total, idx, phase;
    logic [15:0] lfsr, misr, gold;
    logic        so, exp_pass, exp_pass_f;
    logic [8:0]  po, exp_vec, obs_vec;
    logic [15:0] obs_sig;
    logic [2:0]  first_bits;
    if (sel == 0) begin
      c_len = 16; p_cnt = 30; lfsr = 16'hACE1; gold = GOLD_A; start_a = 1'b1;
    end else begin
      c_len = 1;  p_cnt = 1;  lfsr = B_SEED;   gold = 16'h0000; start_b = 1'b1;
    end
    misr = '0; exp_pass = 1'b0; exp_pass_f = 1'b0; first_bits = '0;
    total = p_cnt * (c_len + 1) + c_len + 1;
    @(posedge clock);
    for (int n = 1; n <= total; n++) begin
      @(negedge clock);
      if (n == abort_at) begin
        reset = 1'b0;
        #1;
        check("abort_outputs_a", 32'(a_all), 32'h0);
        check("abort_outputs_f", 32'(f_all), 32'h0);
        return;
      end
      if (sel != 0) begin
        b_scan_out = stuck ? 1'b1 : 1'($urandom);
        b_po_in    = 9'($urandom);
      end
      idx = n - 1;
      if (idx < p_cnt * (c_len + 1)) phase = (idx % (c_len + 1) < c_len) ? 0 : 1;
      else phase = (idx - p_cnt * (c_len + 1) < c_len) ? 2 : 3;
      exp_vec = {(phase == 0 || phase == 2), (phase == 0) && lfsr[15],
                 (phase == 1) ? lfsr[4:0] : 5'b0, 1'b1, 1'b0};
      obs_vec = (sel == 0) ? a_vec : b_vec;
      obs_sig = (sel == 0) ? a_sig : b_sig;
      so      = (sel == 0) ? a_scan_out : b_scan_out;
      po      = (sel == 0) ? a_po_in : b_po_in;
      check("run_outputs", 32'(obs_vec), 32'(exp_vec));
      check("run_signature", 32'(obs_sig), 32'(misr));
      if (sel == 0 && n <= 3) begin
        first_bits = {first_bits[1:0], a_scan_in};
        if (n == 3) check("first_scan_in_bits", 32'(first_bits), 32'h5);
      end
      case (phase)
        0: begin misr = misr_next(misr, {15'b0, so}); lfsr = lfsr_next(lfsr); end
        1: misr = misr_next(misr, {7'b0, po});
        2: misr = misr_next(misr, {15'b0, so});
        default: begin exp_pass = (misr == gold); exp_pass_f = (misr == (gold ^ 16'h0001)); end
      endcase
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      obs_vec = (sel == 0) ? a_vec : b_vec;
      obs_sig = (sel == 0) ? a_sig : b_sig;
      check("done_outputs", 32'(obs_vec), 32'h1);
      check("done_pass", 32'((sel == 0) ? a_pass : b_pass), 32'(exp_pass));
      check("done_signature", 32'(obs_sig), 32'(misr));
      if (sel == 0) check("done_fail_instance", 32'({f_vec, f_pass, f_sig}),
                          32'({9'h1, exp_pass_f, misr}));
    end
  endtask

  initial begin
    reset = 1'b0; start_a = 1'b1; start_b = 1'b1;
    b_scan_out = 1'b0; b_po_in = '0;
    repeat (3) @(negedge clock);
    check("reset_a", 32'(a_all), 32'h0);
    check("reset_f", 32'(f_all), 32'h0);
    check("reset_b", 32'(b_all), 32'h0);
    repeat (2) @(negedge clock);
    check("reset_hold_a", 32'(a_all), 32'h0);
    start_b = 1'b0;
    reset   = 1'b1;

    // Full run straight out of reset: pass instance matches, flipped-golden instance fails.
    run_bist(0, 0, 1'b0);
    check("pass_run_pass", 32'(a_pass), 32'h1);
    check("pass_run_sig", 32'(a_sig), 32'(GOLD_A));
    check("fail_run_pass", 32'(f_pass), 32'h0);

    // One-cycle drop of start returns to IDLE, then a second identical run.
    start_a = 1'b0;
    @(negedge clock);
    check("idle_after_drop", 32'(a_vec), 32'h0);
    run_bist(0, 0, 1'b0);
    check("second_run_sig", 32'(a_sig), 32'(GOLD_A));

    // Abort with reset mid-run, then restart from scratch.
    start_a = 1'b0;
    @(negedge clock);
    run_bist(0, $urandom_range(100, 500), 1'b0);
    start_a = 1'b0;
    repeat (2) @(negedge clock);
    check("abort_held", 32'(a_all), 32'h0);
    reset = 1'b1;
    repeat ($urandom_range(0, 4)) @(negedge clock);
    run_bist(0, 0, 1'b0);
    check("restart_sig", 32'(a_sig), 32'(GOLD_A));
    check("restart_pass", 32'(a_pass), 32'h1);
    start_a = 1'b0;

    // Minimal 1x1 controller with random responses, plus a stuck-at-1 scan_out run.
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      run_bist(1, 0, (i == 5));
      start_b = 1'b0;
      @(negedge clock);
      check("b_idle_after_drop", 32'(b_vec), 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
